// File: rtl/desplazador_pkg.sv
// desplazador_pkg
// Shared definitions for the vector shift/rotate unit:
//   op_e        - operation encoding (ROR, ROL, SRL, SRA)
//   DEF_LANES   - default number of lanes per vector
//   DEF_WIDTH   - default element width
//   lo_mask()   - mask of the amount bits applied in the second stage
package desplazador_pkg;

    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_ROL = 2'b01,
        OP_SRL = 2'b10,
        OP_SRA = 2'b11
    } op_e;

    localparam int DEF_LANES = 4;
    localparam int DEF_WIDTH = 8;

    // The first stage handles amt[SH_W-1:SH_W/2] and the second the rest.
    // With a 1-bit amount that split would leave nothing for the second stage,
    // so the whole amount is pushed there instead.
    function automatic int lo_mask(input int sh_w);
        if (sh_w <= 1) begin
            return 1;
        end
        return (1 << (sh_w / 2)) - 1;
    endfunction

endpackage

// File: rtl/desplazador_carril.sv
// desplazador_carril
// Combinational single-lane shifter, one pipeline stage worth of work.
// Ports:
//   op   - operation (op_e)
//   amt  - shift amount, SH_W bits (modulo WIDTH by construction)
//   din  - lane operand, WIDTH bits
//   dout - shifted/rotated lane result, WIDTH bits
module desplazador_carril
    import desplazador_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  op_e              op,
    input  logic [SH_W-1:0]  amt,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [2*WIDTH-1:0]      dbl;
    logic [SH_W-1:0]         rol_amt;
    logic signed [WIDTH-1:0] din_s;

    // Rotates are taken as the low half of the doubled operand shifted right;
    // a left rotate is the right rotate by the complementary amount.
    assign dbl     = {din, din};
    assign rol_amt = SH_W'(WIDTH - int'(amt));
    assign din_s   = din;

    always_comb begin
        dout = din;
        case (op)
            OP_ROR:  dout = WIDTH'(dbl >> amt);
            OP_ROL:  dout = WIDTH'(dbl >> rol_amt);
            OP_SRL:  dout = din >> amt;
            OP_SRA:  dout = din_s >>> amt;
            default: dout = din;
        endcase
    end

endmodule

// File: rtl/desplazador_vectorial.sv
// desplazador_vectorial
// Two-stage elastic vector shift/rotate unit. LANES independent WIDTH-bit
// elements, each with its own amount or lane 0's amount broadcast.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - operand handshake
//   op                   - 00 ROR, 01 ROL, 10 SRL, 11 SRA
//   amt_bcast            - 1: all lanes use lane 0's amount
//   amt_in               - per-lane amounts, lane i at [i*SH_W +: SH_W]
//   data_in              - operand vector, lane i at [i*WIDTH +: WIDTH]
//   out_valid / out_ready- result handshake
//   data_out             - result vector, same packing as data_in
//   zero_out             - bit i set when result lane i is zero (only while valid)
module desplazador_vectorial
    import desplazador_pkg::*;
#(
    parameter  int LANES = DEF_LANES,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int SH_W  = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic                   amt_bcast,
    input  logic [LANES*SH_W-1:0]  amt_in,
    input  logic [LANES*WIDTH-1:0] data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       zero_out
);

    localparam int              LO_MASK_I = lo_mask(SH_W);
    localparam logic [SH_W-1:0] LO_MASK   = LO_MASK_I[SH_W-1:0];
    localparam logic [SH_W-1:0] HI_MASK   = ~LO_MASK;

    logic [LANES-1:0][WIDTH-1:0] data_p0, coarse_p0;
    logic [LANES-1:0][SH_W-1:0]  amt_in_p0, amt_p0;
    op_e                         op_p0;

    logic [LANES-1:0][WIDTH-1:0] data_p1, fine_p1;
    logic [LANES-1:0][SH_W-1:0]  amt_p1;
    logic [LANES-1:0]            zero_p1;
    op_e                         op_p1;
    logic                        vld_p1;

    logic [LANES-1:0][WIDTH-1:0] data_p2;
    logic [LANES-1:0]            zero_p2;
    logic                        vld_p2;

    logic s1_adv, s2_adv;

    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;

    assign data_p0   = data_in;
    assign amt_in_p0 = amt_in;
    assign op_p0     = op_e'(op);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign amt_p0[i] = amt_bcast ? amt_in_p0[0] : amt_in_p0[i];

        desplazador_carril #(.WIDTH(WIDTH)) u_coarse (
            .op   (op_p0),
            .amt  (amt_p0[i] & HI_MASK),
            .din  (data_p0[i]),
            .dout (coarse_p0[i])
        );

        // For SRA the coarse result's MSB is still the original sign, so the
        // fine stage fills correctly from its own operand.
        desplazador_carril #(.WIDTH(WIDTH)) u_fine (
            .op   (op_p1),
            .amt  (amt_p1[i] & LO_MASK),
            .din  (data_p1[i]),
            .dout (fine_p1[i])
        );

        assign zero_p1[i] = ~|fine_p1[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (s1_adv) vld_p1 <= in_valid;
            if (s2_adv) vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1: operand + coarse shift -------------------------------
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            op_p1   <= op_p0;
            amt_p1  <= amt_p0;
            data_p1 <= coarse_p0;
        end
    end

    // ---- stage 2: fine shift, zero flags, output register ---------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p2 <= '0;
            zero_p2 <= '0;
        end else if (s2_adv && vld_p1) begin
            data_p2 <= fine_p1;
            zero_p2 <= zero_p1;
        end
    end

    assign out_valid = vld_p2;
    assign data_out  = data_p2;
    assign zero_out  = vld_p2 ? zero_p2 : '0;

endmodule

// File: tb/tb_desplazador_vectorial.sv
// Testbench for desplazador_vectorial (LANES=4, WIDTH=8).
module tb_desplazador_vectorial;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        amt_bcast;
    logic [11:0] amt_in;
    logic [31:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  zero_out;

    int n_vec = 0;
    int n_err = 0;

    desplazador_vectorial #(.LANES(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .amt_bcast (amt_bcast),
        .amt_in    (amt_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .zero_out  (zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        bcast;
        logic [11:0] amt;
        logic [31:0] din;
        logic [31:0] exp;
        logic [3:0]  zero;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [11:0] amt4(input int a0, input int a1, input int a2, input int a3);
        return {a3[2:0], a2[2:0], a1[2:0], a0[2:0]};
    endfunction

    // Nibble swap of every byte = ROR by 4 on each lane.
    function automatic logic [31:0] swap_nib(input logic [31:0] v);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) begin
            r[l*8 +: 8] = {v[l*8 +: 4], v[l*8+4 +: 4]};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic b, input logic [11:0] a, input logic [31:0] d);
        op        = o;
        amt_bcast = b;
        amt_in    = a;
        data_in   = d;
        in_valid  = 1'b1;
    endtask

    logic [31:0] held;

    initial begin
        //             op     bc    amounts           data          expected      zero
        tbl[0]  = '{2'b00, 1'b0, amt4(3,3,3,3), 32'hFF800196, 32'hFF1020D2, 4'b0000};
        tbl[1]  = '{2'b01, 1'b0, amt4(3,3,3,3), 32'hFF800196, 32'hFF0408B4, 4'b0000};
        tbl[2]  = '{2'b10, 1'b0, amt4(2,2,2,2), 32'hFF800196, 32'h3F200025, 4'b0010};
        tbl[3]  = '{2'b11, 1'b0, amt4(2,2,2,2), 32'hFF800196, 32'hFFE000E5, 4'b0010};
        tbl[4]  = '{2'b11, 1'b0, amt4(7,7,7,7), 32'hC3017F80, 32'hFF0000FF, 4'b0110};
        tbl[5]  = '{2'b10, 1'b0, amt4(7,7,7,7), 32'hC3017F80, 32'h01000001, 4'b0110};
        tbl[6]  = '{2'b00, 1'b0, amt4(0,1,4,7), 32'h81818181, 32'h0318C081, 4'b0000};
        tbl[7]  = '{2'b00, 1'b1, amt4(1,4,7,3), 32'h81818181, 32'hC0C0C0C0, 4'b0000};
        tbl[8]  = '{2'b10, 1'b0, amt4(1,1,1,1), 32'hF0800201, 32'h78400100, 4'b0001};
        tbl[9]  = '{2'b01, 1'b0, amt4(0,1,2,5), 32'hA5A5A5A5, 32'hB4964BA5, 4'b0000};
        tbl[10] = '{2'b11, 1'b0, amt4(0,1,3,6), 32'hB0B0B0B0, 32'hFEF6D8B0, 4'b0000};
        tbl[11] = '{2'b10, 1'b0, amt4(0,0,0,0), 32'h00000000, 32'h00000000, 4'b1111};
        tbl[12] = '{2'b11, 1'b1, amt4(0,7,7,7), 32'h123456F8, 32'h123456F8, 4'b0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'b00;
        amt_bcast = 1'b0;
        amt_in    = '0;
        data_in   = '0;
        #12;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset data_out", data_out, 32'd0);
        chk("reset zero_out", 32'(zero_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reset in_ready", 32'(in_ready), 32'd1);

        // Table: one vector at a time through an empty pipeline.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].op, tbl[i].bcast, tbl[i].amt, tbl[i].din);
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d latency", i), 32'(out_valid), 32'd0);
            tick();
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d data", i), data_out, tbl[i].exp);
            chk($sformatf("v%0d zero", i), 32'(zero_out), 32'(tbl[i].zero));
            tick();
        end

        // Backpressure: three offered, two accepted, outputs held.
        out_ready = 1'b0;
        drive(2'b00, 1'b0, amt4(1,1,1,1), 32'h02020202);
        chk("bp A in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(2'b00, 1'b0, amt4(1,1,1,1), 32'h04040404);
        chk("bp B in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(2'b00, 1'b0, amt4(1,1,1,1), 32'h01010101);
        chk("bp full in_ready", 32'(in_ready), 32'd0);
        chk("bp out_valid", 32'(out_valid), 32'd1);
        chk("bp hold A", data_out, 32'h01010101);
        held = data_out;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp stall%0d in_ready", k), 32'(in_ready), 32'd0);
            chk($sformatf("bp stall%0d data", k), data_out, held);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp out B valid", 32'(out_valid), 32'd1);
        chk("bp out B", data_out, 32'h02020202);
        tick();
        chk("bp out C valid", 32'(out_valid), 32'd1);
        chk("bp out C", data_out, 32'h80808080);
        tick();
        chk("bp drained", 32'(out_valid), 32'd0);

        // Streaming: one vector per cycle, ROR by 4 swaps nibbles.
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                drive(2'b00, 1'b1, amt4(4,0,0,0), 32'h1F2E3D4C + 32'(c) * 32'h01010101);
            end else begin
                in_valid = 1'b0;
            end
            chk($sformatf("stream%0d in_ready", c), 32'(in_ready), 32'd1);
            tick();
            if (c >= 1 && c <= 5) begin
                chk($sformatf("stream%0d valid", c), 32'(out_valid), 32'd1);
                chk($sformatf("stream%0d data", c), data_out,
                    swap_nib(32'h1F2E3D4C + 32'(c - 1) * 32'h01010101));
            end else begin
                chk($sformatf("stream%0d valid", c), 32'(out_valid), 32'd0);
            end
        end

        // Reset with both stages full.
        out_ready = 1'b0;
        drive(2'b01, 1'b0, amt4(1,2,3,4), 32'h11223344);
        tick();
        tick();
        in_valid = 1'b0;
        chk("rst pre out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst async out_valid", 32'(out_valid), 32'd0);
        chk("rst async data", data_out, 32'd0);
        chk("rst async zero", 32'(zero_out), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rst post%0d valid", k), 32'(out_valid), 32'd0);
            chk($sformatf("rst post%0d in_ready", k), 32'(in_ready), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/desplazador_vectorial.md
# desplazador_vectorial

Parametrised, pipelined vector shift/rotate unit for the vector datapath. It applies one of four shift operations to `LANES` independent `WIDTH`-bit elements, each with its own shift amount or a single broadcast amount. The unit sits between operand read and writeback, is fully elastic (valid/ready on both sides), and has a fixed two-stage pipeline.

## Interface
- `LANES`, 4: number of elements per vector; ≥1.
- `WIDTH`, 8: element width in bits; power of two, ≥2.
- `SH_W`, `$clog2(WIDTH)`: shift-amount width per lane (derived; not overridden).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input operands valid.
- `in_ready` out 1: unit accepts operands this cycle.
- `op` in 2: 00 ROR, 01 ROL, 10 SRL (logical right), 11 SRA (arithmetic right).
- `amt_bcast` in 1: 1 = every lane uses lane 0's amount.
- `amt_in` in `LANES*SH_W`: per-lane shift amounts, lane i at bits `[i*SH_W +: SH_W]`.
- `data_in` in `LANES*WIDTH`: operand vector, lane i at `[i*WIDTH +: WIDTH]`.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `data_out` out `LANES*WIDTH`: result vector, same lane packing.
- `zero_out` out `LANES`: bit i = 1 when result lane i is all zeros.

## Operation
- Transfer on input when `in_valid && in_ready`; on output when `out_valid && out_ready`.
- Amount is `SH_W` bits, so shifts are modulo `WIDTH` by construction; amount 0 passes data unchanged for every op.
- ROR: bit j of result = bit `(j+amt) mod WIDTH` of operand. ROL: bit j = bit `(j-amt) mod WIDTH`. Combination is bitwise, never logical-OR.
- SRL fills vacated MSBs with 0; SRA fills with the operand's original MSB.
- Stage 1 (S1): registers op, broadcast-resolved amounts, and operand shifted by the amount's upper bits `amt[SH_W-1:SH_W/2]` (value `amt & ~LO_MASK`). Stage 2 (S2): applies remaining lower bits, computes `zero_out`, drives outputs. For `WIDTH=2`, S1 shifts by 0 and S2 by the full amount.
- SRA sign fill in S2 uses S1's result MSB, which equals the original sign.
- Lanes are fully independent; no carry or bit movement between lanes.
- Each stage holds a valid bit; stage advances when its successor is empty or advancing. `s2_adv = !s2_valid || out_ready`; `s1_adv = !s1_valid || s2_adv`; `in_ready = s1_adv`.
- Results leave in acceptance order; no reordering, no drops, no duplication.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): `s1_valid`, `s2_valid`, `out_valid` = 0; `data_out` = 0; `zero_out` = 0 (not asserted while invalid); `in_ready` = 1 whenever `rst_n` is high and pipeline empty.
- Latency: operand accepted at edge N appears with `out_valid`=1 after edge N+2 (visible in cycle N+2) when `out_ready` is held high.
- Throughput: one vector per cycle with `out_ready`=1 continuously.
- Backpressure: `out_ready`=0 with both stages full ⇒ `in_ready`=0 combinationally in same cycle; `data_out`/`zero_out` stable while `out_valid && !out_ready`.
- Simultaneous output accept and input accept in a full pipeline: both occur; S1 moves to S2, new operand enters S1.
- `in_ready` depends combinationally on `out_ready`; no combinational path from `in_valid`/`data_in` to outputs.
- Reset asserted mid-operation: all in-flight vectors discarded immediately; no result emitted for them after release.

## Structure
- Package `desplazador_pkg`: `op_e` enum (`OP_ROR`, `OP_ROL`, `OP_SRL`, `OP_SRA`), default `LANES`/`WIDTH` constants, helper for `LO_MASK`.
- Sub-module `desplazador_carril`: combinational single-lane, single-stage shifter (inputs op, amount, operand; parameter `WIDTH`); instantiated `LANES` times in each stage via generate. Pipeline registers and handshake live in the top module.

## Test plan
- `LANES`=4, `WIDTH`=8, lane0 `0x96`, ROR amt 3 -> `0xD2`; ROL amt 3 -> `0xB4`; result 2 cycles after acceptance.
- SRL amt 2 on `0x96` -> `0x25`; SRA amt 2 -> `0xE5`; SRA amt 7 on `0x80` -> `0xFF`; SRL amt 7 on `0x80` -> `0x01`.
- Per-lane amounts 0,1,4,7 on all-`0x81` ROR -> `0x81`,`0xC0`,`0x18`,`0x03`; repeat with `amt_bcast`=1, lane0 amt 1 -> all `0xC0`.
- SRL amt 1 on `0x01` -> lane `0x00`, `zero_out` bit set only for that lane.
- Hold `out_ready`=0, offer 3 vectors back-to-back -> only 2 accepted, `in_ready`=0, outputs stable; release -> 3 results in order, no loss/duplication, then 1/cycle streaming.
- Assert `rst_n`=0 with both stages full -> `out_valid`=0 immediately; after release no stale result appears, `in_ready`=1.
